// File: rtl/fetch_unit_pkg.sv
// Shared core package: fetch FSM encoding, NOP/reset-PC constants and the
// opcode constants consumed by decode.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Sequential successor address; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register that parks a fetched word and its address while
// decode is stalled. Clear wins over load.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        vld,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d   = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign vld   = vld_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: REQ/HOLD/DROP machine with a one-entry skid buffer.
// Optional misaligned-redirect trap enabled by macro FETCH_MISALIGN_CHK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrCode,
  output logic [31:0] PC,
  output logic [31:0] PC_4,
  output logic        instr_valid
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pco_q, pco_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         vld_q, vld_d;

  logic         skid_load, skid_clear, skid_vld;
  logic [31:0]  skid_instr, skid_pc;
  logic [31:0]  redir_tgt;
  logic         req_ok;
  logic         ack;

`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (redirect && (redirect_pc[1:0] != 2'b00)) mis_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign redir_tgt        = redirect_pc;
  assign req_ok           = ~mis_q;
  assign fetch_misaligned = mis_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redir_tgt           = {redirect_pc[31:2], 2'b00};
  assign req_ok              = 1'b1;
`endif

  // An acknowledge only counts against a request actually on the bus.
  assign imem_req  = ~rst & req_ok & (state_q != ST_HOLD);
  assign imem_addr = pc_q;
  assign ack       = imem_ack & imem_req;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .instr_in (imem_rdata),
    .pc_in    (pc_q),
    .vld      (skid_vld),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      instr_q <= NOP_INSTR;
      pco_q   <= '0;
      pc4_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      pc4_q   <= pc4_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (redirect)         state_d = ack ? ST_REQ : ST_DROP;
        else if (ack && stall) state_d = ST_HOLD;
      end
      ST_HOLD: if (redirect || !stall) state_d = ST_REQ;
      ST_DROP: if (ack) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  // Redirect squashes the output slot and skid entry regardless of stall.
  always_comb begin
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    instr_d    = instr_q;
    pco_d      = pco_q;
    pc4_d      = pc4_q;
    vld_d      = vld_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (redirect) begin
      vld_d      = 1'b0;
      instr_d    = NOP_INSTR;
      skid_clear = 1'b1;
    end
    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          if (ack) pc_d  = redir_tgt;
          else     tgt_d = redir_tgt;
        end else if (ack && !stall) begin
          instr_d = imem_rdata;
          pco_d   = pc_q;
          pc4_d   = pc_next(pc_q);
          vld_d   = 1'b1;
          pc_d    = pc_next(pc_q);
        end else if (ack) begin
          skid_load = 1'b1;
          pc_d      = pc_next(pc_q);
        end else if (!stall) begin
          vld_d   = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d = redir_tgt;
        end else if (!stall && skid_vld) begin
          instr_d    = skid_instr;
          pco_d      = skid_pc;
          pc4_d      = pc_next(skid_pc);
          vld_d      = 1'b1;
          skid_clear = 1'b1;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          if (ack) pc_d  = redir_tgt;
          else     tgt_d = redir_tgt;
        end else if (ack) begin
          pc_d = tgt_q;
        end
      end
      default: ;
    endcase
  end

  assign instrCode   = instr_q;
  assign PC          = pco_q;
  assign PC_4        = pc4_q;
  assign instr_valid = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run checked against a program-order reference model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, imem_ack;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, instrCode, PC, PC_4;
  logic        instr_valid;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misaligned;
`endif

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instrCode   (instrCode),
    .PC          (PC),
    .PC_4        (PC_4),
    .instr_valid (instr_valid)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b1; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    total++; if (instrCode !== NOP) begin bad++; $display("FAIL rst_instr: got %h want %h", instrCode, NOP); end
    total++; if (PC !== 32'h0 || PC_4 !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h/%h want 0/0", PC, PC_4); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
`ifdef FETCH_MISALIGN_CHK_EN
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL rst_mis: got %b want 0", fetch_misaligned); end
`endif
  endtask

  task automatic test_zero_wait();
    do_reset();
    imem_ack = 1'b1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL zw_c1: got req=%b addr=%h vld=%b want 1/0/0", imem_req, imem_addr, instr_valid); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (instr_valid !== 1'b1 || PC !== 32'(4*i) || instrCode !== mem_word(32'(4*i))
                   || PC_4 !== 32'(4*i+4) || imem_addr !== 32'(4*i+4)) begin
        bad++; $display("FAIL zw_stream%0d: got vld=%b pc=%h pc4=%h ins=%h addr=%h want pc=%h", i, instr_valid, PC, PC_4, instrCode, imem_addr, 32'(4*i)); end
    end
  endtask

  task automatic test_latency3();
    logic [31:0] exp_pc;
    logic        want_v;
    do_reset();
    exp_pc = 32'h0;
    for (int k = 0; k < 9; k++) begin
      imem_ack = (k % 3 == 2);
      want_v   = imem_ack;
      cyc();
      total++;
      if (want_v) begin
        if (instr_valid !== 1'b1 || PC !== exp_pc || instrCode !== mem_word(exp_pc)) begin
          bad++; $display("FAIL lat3_pulse%0d: got vld=%b pc=%h want 1/%h", k, instr_valid, PC, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end else if (instr_valid !== 1'b0 || instrCode !== NOP) begin
        bad++; $display("FAIL lat3_bubble%0d: got vld=%b ins=%h want 0/%h", k, instr_valid, instrCode, NOP);
      end
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    imem_ack = 1'b1;
    repeat (4) cyc();
    total++; if (PC !== 32'hC || imem_addr !== 32'h10) begin bad++; $display("FAIL skid_pre: got pc=%h addr=%h want c/10", PC, imem_addr); end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (instr_valid !== 1'b1 || PC !== 32'hC || instrCode !== mem_word(32'hC) || PC_4 !== 32'h10) begin
        bad++; $display("FAIL skid_frozen%0d: got vld=%b pc=%h ins=%h want 1/c/%h", i, instr_valid, PC, instrCode, mem_word(32'hC)); end
    end
    stall = 1'b0;
    cyc();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h10 || instrCode !== mem_word(32'h10) || PC_4 !== 32'h14) begin
      bad++; $display("FAIL skid_release: got vld=%b pc=%h ins=%h want 1/10/%h", instr_valid, PC, instrCode, mem_word(32'h10)); end
    cyc();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h14) begin bad++; $display("FAIL skid_after: got vld=%b pc=%h want 1/14", instr_valid, PC); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    imem_ack = 1'b1;
    repeat (16) cyc();
    imem_ack = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    total++; if (instr_valid !== 1'b0 || instrCode !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      bad++; $display("FAIL drop_enter: got vld=%b ins=%h req=%b addr=%h want 0/%h/1/40", instr_valid, instrCode, imem_req, imem_addr, NOP); end
    cyc();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL drop_hold_addr: got req=%b addr=%h want 1/40", imem_req, imem_addr); end
    imem_ack = 1'b1;
    cyc();
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL drop_discard: got vld=%b addr=%h want 0/200", instr_valid, imem_addr); end
    cyc();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h200 || instrCode !== mem_word(32'h200)) begin
      bad++; $display("FAIL drop_target: got vld=%b pc=%h want 1/200", instr_valid, PC); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    imem_ack = 1'b1;
    cyc();
    stall = 1'b1;
    cyc();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL hold_enter: got vld=%b pc=%h req=%b want 1/0/0", instr_valid, PC, imem_req); end
    redirect = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    total++; if (instr_valid !== 1'b0 || instrCode !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      bad++; $display("FAIL hold_redirect: got vld=%b ins=%h req=%b addr=%h want 0/%h/1/300", instr_valid, instrCode, imem_req, imem_addr, NOP); end
    stall = 1'b0;
    cyc();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h300 || instrCode !== mem_word(32'h300)) begin
      bad++; $display("FAIL hold_target: got vld=%b pc=%h want 1/300", instr_valid, PC); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFF8 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_redirect: got addr=%h vld=%b want fffffff8/0", imem_addr, instr_valid); end
    cyc();
    total++; if (PC !== 32'hFFFF_FFF8 || PC_4 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_a: got %h/%h want fffffff8/fffffffc", PC, PC_4); end
    cyc();
    total++; if (PC !== 32'hFFFF_FFFC || PC_4 !== 32'h0 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_b: got pc=%h pc4=%h addr=%h want fffffffc/0/0", PC, PC_4, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ack = 1'b1;
    repeat (2) cyc();
    imem_ack = 1'b0;
    cyc();
    #2 rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_async: got req=%b addr=%h vld=%b want 0/0/0", imem_req, imem_addr, instr_valid); end
    cyc();
    rst = 1'b0; imem_ack = 1'b1;
    #1;
    cyc();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h0 || instrCode !== mem_word(32'h0)) begin
      bad++; $display("FAIL midrst_first: got vld=%b pc=%h want 1/0", instr_valid, PC); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, s_instr, s_pc, s_pc4, p_addr;
    logic        s_vld, p_req, p_ack, p_stall, p_redir;
    do_reset();
    exp_pc = 32'h0;
    for (int n = 0; n < 600; n++) begin
      s_instr = instrCode; s_pc = PC; s_pc4 = PC_4; s_vld = instr_valid;
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      imem_ack    = ($urandom_range(0, 2) != 0);
      p_req = imem_req; p_addr = imem_addr; p_ack = imem_ack && imem_req;
      p_stall = stall; p_redir = redirect;
      if (redirect) exp_pc = redirect_pc;
      cyc();
      if (p_req && !p_ack) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          bad++; $display("FAIL rnd_addr_stable@%0d: got req=%b addr=%h want 1/%h", n, imem_req, imem_addr, p_addr); end
      end
      total++;
      if (p_redir) begin
        if (instr_valid !== 1'b0 || instrCode !== NOP) begin
          bad++; $display("FAIL rnd_squash@%0d: got vld=%b ins=%h want 0/%h", n, instr_valid, instrCode, NOP); end
      end else if (p_stall) begin
        if (instr_valid !== s_vld || instrCode !== s_instr || PC !== s_pc || PC_4 !== s_pc4) begin
          bad++; $display("FAIL rnd_frozen@%0d: got vld=%b pc=%h ins=%h want %b/%h/%h", n, instr_valid, PC, instrCode, s_vld, s_pc, s_instr); end
      end else if (instr_valid === 1'b1) begin
        if (PC !== exp_pc || instrCode !== mem_word(exp_pc) || PC_4 !== exp_pc + 32'd4) begin
          bad++; $display("FAIL rnd_order@%0d: got pc=%h ins=%h pc4=%h want pc=%h", n, PC, instrCode, PC_4, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end else if (instrCode !== NOP) begin
        bad++; $display("FAIL rnd_bubble@%0d: got ins=%h want %h", n, instrCode, NOP);
      end
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    do_reset();
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0) begin
        bad++; $display("FAIL mis_sticky%0d: got mis=%b req=%b want 1/0", i, fetch_misaligned, imem_req); end
      cyc();
    end
    do_reset();
    total++; if (fetch_misaligned !== 1'b0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL mis_clear: got mis=%b req=%b want 0/1", fetch_misaligned, imem_req); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency3();
    test_stall_skid();
    test_redirect_drop();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef FETCH_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
